// File: rtl/id_issue_stage.sv
// Decode/issue stage between IF/ID and EX of the in-order RV64 pipeline.
// Holds the architectural register file, resolves operands, detects hazards and
// registers one instruction for EX behind a valid/ready handshake.
// Optional feature macro: ID_FWD_EN (defined = EX/MEM/WB forwarding; undefined =
// RF-only operands with WB write-through, stalling on any in-flight EX/MEM producer).
module id_issue_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned RW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_ins,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [1:0]        in_src1_sel,
  input  logic [1:0]        in_src2_sel,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              ex_wen,
  input  logic [RW-1:0]     ex_rd,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              mem_wen,
  input  logic [RW-1:0]     mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_wen,
  input  logic [RW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_ins,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RW-1:0]     out_rd,
  output logic              out_wen,
  output logic              out_is_load,
  output logic [XLEN-1:0]   out_src_a,
  output logic [XLEN-1:0]   out_src_b,
  output logic [XLEN-1:0]   out_rs2_data,
  input  logic [RW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rs1_val, rs2_val, src_a, src_b;
  logic            reads_ex, hazard, fire;

  // Operand value for one source index, highest-priority producer wins.
  function automatic logic [XLEN-1:0] resolve(input logic [RW-1:0] idx,
                                               input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] val;
    val = rf_val;
    if (wb_wen && wb_rd == idx) val = wb_data;
`ifdef ID_FWD_EN
    if (mem_wen && mem_rd == idx) val = mem_data;
    if (ex_wen && !ex_is_load && ex_rd == idx) val = ex_data;
`endif
    if (idx == '0) val = '0;
    return val;
  endfunction

  // Register file: synchronous clear, single WB write port, x0 never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_wen && wb_rd != '0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  // Operand resolution and source muxing.
  always_comb begin
    rs1_val = resolve(in_rs1, rf_q[in_rs1]);
    rs2_val = resolve(in_rs2, rf_q[in_rs2]);
    unique case (in_src1_sel)
      2'd0:    src_a = rs1_val;
      2'd2:    src_a = in_pc;
      default: src_a = '0;
    endcase
    unique case (in_src2_sel)
      2'd0:    src_b = rs2_val;
      2'd1:    src_b = in_imm;
      2'd2:    src_b = XLEN'(4);
      default: src_b = '0;
    endcase
  end

  // Hazard detection against in-flight producers.
  always_comb begin
    reads_ex = (in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd);
`ifdef ID_FWD_EN
    hazard = ex_wen && ex_is_load && ex_rd != '0 && reads_ex;
`else
    // Without forwarding any writer still in EX or MEM must drain first.
    hazard = (ex_wen && ex_rd != '0 && reads_ex) ||
             (mem_wen && mem_rd != '0 &&
              ((in_use_rs1 && in_rs1 == mem_rd) || (in_use_rs2 && in_rs2 == mem_rd)));
`endif
  end

`ifndef ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_data, mem_data, ex_is_load};
`endif

  assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  // Output register: flush beats hold, hold beats fire, otherwise bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_ins      <= '0;
      out_ctrl     <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
      out_is_load  <= 1'b0;
      out_src_a    <= '0;
      out_src_b    <= '0;
      out_rs2_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_valid && !out_ready) begin
      out_valid <= 1'b1;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_ins      <= in_ins;
      out_ctrl     <= in_ctrl;
      out_rd       <= in_rd;
      out_wen      <= in_wen;
      out_is_load  <= in_is_load;
      out_src_a    <= src_a;
      out_src_b    <= src_b;
      out_rs2_data <= rs2_val;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Stall performance counter, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
